// File: rtl/lamp_mon_pkg.sv
// ----------------------------------------------------------------------------
// lamp_mon_pkg
// Shared types and constants for the tail-lamp sequence monitor.
//   mode_t      : decoded lamp mode (OFF, LEFT, RIGHT, HAZARD)
//   mon_state_t : monitor tracking states
//   err_code_t  : sticky error classification
//   PAT_*       : 6-bit lamp patterns, [5:3] left group, [2:0] right group
// Helper functions decode a monitor state into its mode, step and the
// lamp pattern that is expected to be shown while in that state.
// ----------------------------------------------------------------------------
package lamp_mon_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        HAZ,
        RESYNC
    } mon_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_STALL   = 2'b10
    } err_code_t;

    localparam logic [5:0] PAT_OFF = 6'b000_000;
    localparam logic [5:0] PAT_L1  = 6'b001_000;
    localparam logic [5:0] PAT_L2  = 6'b011_000;
    localparam logic [5:0] PAT_L3  = 6'b111_000;
    localparam logic [5:0] PAT_R1  = 6'b000_100;
    localparam logic [5:0] PAT_R2  = 6'b000_110;
    localparam logic [5:0] PAT_R3  = 6'b000_111;
    localparam logic [5:0] PAT_HAZ = 6'b111_111;

    // Mode reported for a given tracking state.
    function automatic mode_t state_mode(input mon_state_t s);
        mode_t m;
        case (s)
            L1, L2, L3: m = LEFT;
            R1, R2, R3: m = RIGHT;
            HAZ:        m = HAZARD;
            default:    m = OFF;
        endcase
        return m;
    endfunction

    // Sequence step reported for a given tracking state.
    function automatic logic [1:0] state_step(input mon_state_t s);
        logic [1:0] k;
        case (s)
            L1, R1, HAZ: k = 2'd1;
            L2, R2:      k = 2'd2;
            L3, R3:      k = 2'd3;
            default:     k = 2'd0;
        endcase
        return k;
    endfunction

    // Pattern the lamps are expected to hold while sitting in a state.
    // Used to recognise repeats for the stall check.
    function automatic logic [5:0] state_pattern(input mon_state_t s);
        logic [5:0] p;
        case (s)
            L1:      p = PAT_L1;
            L2:      p = PAT_L2;
            L3:      p = PAT_L3;
            R1:      p = PAT_R1;
            R2:      p = PAT_R2;
            R3:      p = PAT_R3;
            HAZ:     p = PAT_HAZ;
            default: p = PAT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high; clears the count
//   inc   : add one this cycle (ignored once saturated)
//   q     : current count, W bits
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on request, but hold once every bit is set so a long-running
    // system never shows a misleading small value after wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/lamp_seq_monitor.sv
// ----------------------------------------------------------------------------
// lamp_seq_monitor
// Passive checker for the 6-bit tail-lamp vector of the turn-signal FSM.
// Recovers mode and sequence step from the lamp pattern, flags illegal
// transitions and stalled patterns, and counts completed sequences.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high
//   sample_en  : qualifies lamps this cycle (FSM advance strobe)
//   lamps[5:0] : [5:3] left group (bit3 innermost), [2:0] right group
//   err_clr    : clears the sticky error on the next edge
//   mode[1:0]  : 00 off, 01 left, 10 right, 11 hazard
//   step[1:0]  : sequence step 0..3
//   err        : sticky error flag
//   err_code   : 00 none, 01 illegal transition, 10 stall
//   seq_cnt    : completed sequences, saturating
//
// Optional build macro LAMP_MON_SPLIT_CNT_EN adds left_cnt, right_cnt and
// haz_cnt: per-direction saturating completion counters.
// ----------------------------------------------------------------------------
module lamp_seq_monitor
    import lamp_mon_pkg::*;
#(
    parameter int STALL_LIMIT = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [5:0]       lamps,
    input  logic             err_clr,
    output logic [1:0]       mode,
    output logic [1:0]       step,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] seq_cnt
`ifdef LAMP_MON_SPLIT_CNT_EN
    ,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] haz_cnt
`endif
);

    localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

    mon_state_t state, state_n;
    logic [7:0] stall_cnt, stall_n;
    err_code_t  err_new;
    logic       done;
    mode_t      done_mode;
    logic       tracking;

    // State and stall counter register. The stall counter tracks how many
    // times in a row the current non-idle pattern has been repeated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            stall_cnt <= stall_n;
        end
    end

    // Next-state logic. Nothing moves unless sample_en qualifies the lamps.
    // Each state accepts its own pattern (a repeat) or the next pattern of
    // its sequence; anything else is an illegal transition and parks the
    // monitor in RESYNC until the lamps go dark again. Repeats are counted
    // and one repeat too many becomes a stall error.
    always_comb begin
        state_n   = state;
        stall_n   = stall_cnt;
        err_new   = ERR_NONE;
        done      = 1'b0;
        done_mode = OFF;
        tracking  = (state != IDLE) && (state != RESYNC);

        if (sample_en) begin
            case (state)
                IDLE: begin
                    if (lamps == PAT_OFF) begin
                        state_n = IDLE;
                    end else if (lamps == PAT_L1) begin
                        state_n = L1;
                    end else if (lamps == PAT_R1) begin
                        state_n = R1;
                    end else if (lamps == PAT_HAZ) begin
                        state_n = HAZ;
                    end else begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                L1: begin
                    if (lamps == PAT_L2) begin
                        state_n = L2;
                    end else if (lamps != PAT_L1) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                L2: begin
                    if (lamps == PAT_L3) begin
                        state_n = L3;
                    end else if (lamps != PAT_L2) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                L3: begin
                    if (lamps == PAT_OFF) begin
                        state_n   = IDLE;
                        done      = 1'b1;
                        done_mode = LEFT;
                    end else if (lamps != PAT_L3) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                R1: begin
                    if (lamps == PAT_R2) begin
                        state_n = R2;
                    end else if (lamps != PAT_R1) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                R2: begin
                    if (lamps == PAT_R3) begin
                        state_n = R3;
                    end else if (lamps != PAT_R2) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                R3: begin
                    if (lamps == PAT_OFF) begin
                        state_n   = IDLE;
                        done      = 1'b1;
                        done_mode = RIGHT;
                    end else if (lamps != PAT_R3) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                HAZ: begin
                    if (lamps == PAT_OFF) begin
                        state_n   = IDLE;
                        done      = 1'b1;
                        done_mode = HAZARD;
                    end else if (lamps != PAT_HAZ) begin
                        err_new = ERR_ILLEGAL;
                        state_n = RESYNC;
                    end
                end
                RESYNC: begin
                    if (lamps == PAT_OFF) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = RESYNC;
                end
            endcase

            // A repeat of the state's own pattern while tracking a sequence.
            // Once the count already sits at the limit, this repeat would
            // push it past, so it becomes a stall instead of a count.
            if (tracking && (lamps == state_pattern(state))) begin
                if (stall_cnt >= STALL_MAX) begin
                    err_new = ERR_STALL;
                    state_n = RESYNC;
                end else begin
                    stall_n = stall_cnt + 8'd1;
                end
            end

            if (state_n != state) begin
                stall_n = '0;
            end
        end
    end

    // Mode and step are registered alongside the state so they change one
    // clock after the qualifying sample and hold while sample_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= OFF;
            step <= 2'd0;
        end else begin
            mode <= state_mode(state_n);
            step <= state_step(state_n);
        end
    end

    // Sticky error. The first error is kept until cleared; a clear arriving
    // in the same cycle as a new error loses, so the new error is latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if ((err_new != ERR_NONE) && (!err || err_clr)) begin
            err      <= 1'b1;
            err_code <= err_new;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end
    end

    sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done),
        .q     (seq_cnt)
    );

`ifdef LAMP_MON_SPLIT_CNT_EN
    sat_counter #(.W(CNT_W)) u_left_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done && (done_mode == LEFT)),
        .q     (left_cnt)
    );

    sat_counter #(.W(CNT_W)) u_right_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done && (done_mode == RIGHT)),
        .q     (right_cnt)
    );

    sat_counter #(.W(CNT_W)) u_haz_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done && (done_mode == HAZARD)),
        .q     (haz_cnt)
    );
`endif

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// ----------------------------------------------------------------------------
// tb_lamp_seq_monitor
// Directed testbench for lamp_seq_monitor (STALL_LIMIT=8, CNT_W=8).
// Exercises left/right/hazard sequences, sample_en gaps, illegal jumps,
// mid-sequence abort, stall detection with sticky error and err_clr
// priority, counter saturation and asynchronous reset mid-sequence.
// Build with LAMP_MON_SPLIT_CNT_EN to include the split counters.
// ----------------------------------------------------------------------------
module tb_lamp_seq_monitor;
    import lamp_mon_pkg::*;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic [5:0] lamps;
    logic       err_clr;
    logic [1:0] mode;
    logic [1:0] step;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] seq_cnt;
`ifdef LAMP_MON_SPLIT_CNT_EN
    logic [7:0] left_cnt;
    logic [7:0] right_cnt;
    logic [7:0] haz_cnt;
`endif

    int checks;
    int failures;
    int exp_cnt;
    int exp_left;
    int exp_right;
    int exp_haz;
    logic [6:0] obs;
    logic [6:0] exp_st;

    lamp_seq_monitor #(
        .STALL_LIMIT (8),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .lamps     (lamps),
        .err_clr   (err_clr),
        .mode      (mode),
        .step      (step),
        .err       (err),
        .err_code  (err_code),
        .seq_cnt   (seq_cnt)
`ifdef LAMP_MON_SPLIT_CNT_EN
        ,
        .left_cnt  (left_cnt),
        .right_cnt (right_cnt),
        .haz_cnt   (haz_cnt)
`endif
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One qualified sample: pattern and optional err_clr held for one edge.
    task automatic pulse(input logic [5:0] p, input logic clr);
        @(negedge clk);
        lamps     = p;
        sample_en = 1'b1;
        err_clr   = clr;
        @(negedge clk);
        sample_en = 1'b0;
        err_clr   = 1'b0;
    endtask

    // Clocks with sample_en low, lamps showing some unrelated pattern.
    task automatic idle(input int n, input logic [5:0] p);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lamps     = p;
            sample_en = 1'b0;
        end
    endtask

    // err_clr pulse with no qualified sample.
    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        sample_en = 1'b0;
        lamps     = PAT_OFF;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b00_00_0_00) begin
            failures++;
            $display("[TB] FAIL reset_status got=%b exp=%b", obs, 7'b00_00_0_00);
        end
        checks++;
        if (seq_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_seq_cnt got=%0d exp=0", seq_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_left();
        logic [5:0] pats [4];
        logic [6:0] exps [4];
        pats = '{PAT_L1, PAT_L2, PAT_L3, PAT_OFF};
        exps = '{7'b01_01_0_00, 7'b01_10_0_00, 7'b01_11_0_00, 7'b00_00_0_00};
        for (int i = 0; i < 4; i++) begin
            pulse(pats[i], 1'b0);
            obs = {mode, step, err, err_code};
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("[TB] FAIL left_step%0d got=%b exp=%b", i, obs, exps[i]);
            end
        end
        exp_cnt++;
        exp_left++;
        checks++;
        if (seq_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL left_seq_cnt got=%0d exp=%0d", seq_cnt, exp_cnt);
        end
    endtask

    task automatic test_hazard_gaps();
        pulse(PAT_HAZ, 1'b0);
        idle(3, PAT_L2);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b11_01_0_00) begin
            failures++;
            $display("[TB] FAIL haz_hold got=%b exp=%b", obs, 7'b11_01_0_00);
        end
        pulse(PAT_HAZ, 1'b0);
        idle(3, PAT_R3);
        pulse(PAT_OFF, 1'b0);
        exp_cnt++;
        exp_haz++;
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b00_00_0_00) begin
            failures++;
            $display("[TB] FAIL haz_done got=%b exp=%b", obs, 7'b00_00_0_00);
        end
        checks++;
        if (seq_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL haz_seq_cnt got=%0d exp=%0d", seq_cnt, exp_cnt);
        end
    endtask

    task automatic test_right_jump();
        logic [5:0] pats [8];
        logic [6:0] exps [8];
        pats = '{PAT_R1, PAT_R3, PAT_R2, PAT_OFF, PAT_R1, PAT_R2, PAT_R3, PAT_OFF};
        exps = '{7'b10_01_0_00, 7'b00_00_1_01, 7'b00_00_1_01, 7'b00_00_1_01,
                 7'b10_01_1_01, 7'b10_10_1_01, 7'b10_11_1_01, 7'b00_00_1_01};
        for (int i = 0; i < 8; i++) begin
            pulse(pats[i], 1'b0);
            obs = {mode, step, err, err_code};
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("[TB] FAIL right_jump%0d got=%b exp=%b", i, obs, exps[i]);
            end
        end
        exp_cnt++;
        exp_right++;
        checks++;
        if (seq_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL right_seq_cnt got=%0d exp=%0d", seq_cnt, exp_cnt);
        end
    endtask

    // Holding PAT_L1 for 10 samples: the first enters L1, the next eight
    // are repeats 1..8 (allowed), the tenth would be repeat 9 -> stall.
    task automatic test_stall();
        // Run 1: error already latched as 01, stall must not overwrite it.
        for (int i = 0; i < 9; i++) pulse(PAT_L1, 1'b0);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b01_01_1_01) begin
            failures++;
            $display("[TB] FAIL stall1_at_limit got=%b exp=%b", obs, 7'b01_01_1_01);
        end
        pulse(PAT_L1, 1'b0);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b00_00_1_01) begin
            failures++;
            $display("[TB] FAIL stall1_sticky got=%b exp=%b", obs, 7'b00_00_1_01);
        end
        pulse(PAT_OFF, 1'b0);
        clear_err();
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b00_00_0_00) begin
            failures++;
            $display("[TB] FAIL err_clear got=%b exp=%b", obs, 7'b00_00_0_00);
        end
        // Run 2: clean error state, err_clr coincides with the stall.
        for (int i = 0; i < 9; i++) pulse(PAT_L1, 1'b0);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b01_01_0_00) begin
            failures++;
            $display("[TB] FAIL stall2_at_limit got=%b exp=%b", obs, 7'b01_01_0_00);
        end
        pulse(PAT_L1, 1'b1);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b00_00_1_10) begin
            failures++;
            $display("[TB] FAIL stall2_err_wins got=%b exp=%b", obs, 7'b00_00_1_10);
        end
        pulse(PAT_OFF, 1'b0);
        clear_err();
    endtask

    task automatic test_abort();
        pulse(PAT_L1, 1'b0);
        pulse(PAT_OFF, 1'b0);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b00_00_1_01) begin
            failures++;
            $display("[TB] FAIL abort_err got=%b exp=%b", obs, 7'b00_00_1_01);
        end
        checks++;
        if (seq_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL abort_no_count got=%0d exp=%0d", seq_cnt, exp_cnt);
        end
        pulse(PAT_OFF, 1'b0);
        clear_err();
    endtask

    task automatic test_saturation();
        while (exp_cnt < 255) begin
            pulse(PAT_HAZ, 1'b0);
            pulse(PAT_OFF, 1'b0);
            exp_cnt++;
            exp_haz++;
        end
        checks++;
        if (seq_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL sat_reach got=%0d exp=255", seq_cnt);
        end
        pulse(PAT_L1, 1'b0);
        pulse(PAT_L2, 1'b0);
        pulse(PAT_L3, 1'b0);
        pulse(PAT_OFF, 1'b0);
        exp_left++;
        checks++;
        if (seq_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL sat_hold got=%0d exp=255", seq_cnt);
        end
`ifdef LAMP_MON_SPLIT_CNT_EN
        checks++;
        if ({left_cnt, right_cnt, haz_cnt} !== {8'(exp_left), 8'(exp_right), 8'(exp_haz)}) begin
            failures++;
            $display("[TB] FAIL split_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     left_cnt, right_cnt, haz_cnt, exp_left, exp_right, exp_haz);
        end
`endif
    endtask

    task automatic test_reset_mid();
        pulse(PAT_L1, 1'b0);
        pulse(PAT_L2, 1'b0);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b01_10_0_00) begin
            failures++;
            $display("[TB] FAIL mid_in_l2 got=%b exp=%b", obs, 7'b01_10_0_00);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        obs = {mode, step, err, err_code};
        checks++;
        if ((obs !== 7'b00_00_0_00) || (seq_cnt !== 8'd0)) begin
            failures++;
            $display("[TB] FAIL mid_async_reset got=%b cnt=%0d exp=%b cnt=0",
                     obs, seq_cnt, 7'b00_00_0_00);
        end
`ifdef LAMP_MON_SPLIT_CNT_EN
        checks++;
        if ({left_cnt, right_cnt, haz_cnt} !== 24'd0) begin
            failures++;
            $display("[TB] FAIL mid_split_reset got=%0d/%0d/%0d exp=0/0/0",
                     left_cnt, right_cnt, haz_cnt);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        pulse(PAT_L1, 1'b0);
        obs = {mode, step, err, err_code};
        checks++;
        if (obs !== 7'b01_01_0_00) begin
            failures++;
            $display("[TB] FAIL mid_restart_l1 got=%b exp=%b", obs, 7'b01_01_0_00);
        end
    endtask

    // Scenario sequence; each task leaves the monitor idle for the next.
    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt   = 0;
        exp_left  = 0;
        exp_right = 0;
        exp_haz   = 0;
        test_reset();
        test_left();
        test_hazard_gaps();
        test_right_jump();
        test_stall();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
